// File: rtl/neuron_activation_if.sv
// neuron_activation_if: sample, bias and result bus between the weighted sum, the activation stage and its consumer
interface neuron_activation_if #(
  parameter int sum_w = 16,
  parameter int bit_length = 4,
  parameter int cnt_w = 8
);
  logic [sum_w-1:0] in_sum;
  logic in_valid;
  logic in_ready;
  logic [sum_w-1:0] bias_in;
  logic bias_we;
  logic [bit_length-1:0] out_act;
  logic out_sat;
  logic out_valid;
  logic out_ready;
  logic [cnt_w-1:0] sat_count;
  logic sat_clr;
  modport master (
    output in_sum, in_valid, bias_in, bias_we, out_ready, sat_clr,
    input in_ready, out_act, out_sat, out_valid, sat_count
  );
  modport slave (
    input in_sum, in_valid, bias_in, bias_we, out_ready, sat_clr,
    output in_ready, out_act, out_sat, out_valid, sat_count
  );
endinterface

// File: rtl/neuron_activation.sv
// neuron_activation: bias add, arithmetic shift, ReLU and saturation in a two-stage valid/ready pipeline
module neuron_activation #(
  parameter int num_inputs = 2,
  parameter int bit_length = 4,
  parameter int shift = 0,
  parameter int cnt_w = 8
) (
  input logic clk,
  input logic rst_n,
  neuron_activation_if.slave io_bus
);
  localparam int sum_w = 2 * num_inputs * bit_length;
  logic [sum_w-1:0] r_bias;
  logic [sum_w:0] r_s1_sum;
  logic r_s1_valid;
  logic [bit_length-1:0] r_out_act;
  logic r_out_sat;
  logic r_out_valid;
  logic [cnt_w-1:0] r_sat_count;
  logic w_s2_adv;
  logic w_s1_adv;
  logic w_in_ready;
  logic w_s1_load;
  logic signed [sum_w:0] w_shifted;
  logic w_neg;
  logic w_over;
  logic [bit_length-1:0] w_act;
  assign w_s2_adv = !r_out_valid || io_bus.out_ready;
  assign w_s1_adv = r_s1_valid && w_s2_adv;
  assign w_in_ready = !r_s1_valid || w_s2_adv;
  assign w_s1_load = io_bus.in_valid && w_in_ready;
  assign w_shifted = $signed(r_s1_sum) >>> shift;
  assign w_neg = w_shifted[sum_w];
  assign w_over = !w_neg && |w_shifted[sum_w-1:bit_length];
  assign w_act = w_neg ? '0 : w_over ? '1 : w_shifted[bit_length-1:0];
  assign io_bus.in_ready = w_in_ready;
  assign io_bus.out_act = r_out_act;
  assign io_bus.out_sat = r_out_sat;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.sat_count = r_sat_count;
  // bias register; a sample accepted on the same edge still sees the old value
  always_ff @(posedge clk)
    if (!rst_n) r_bias <= '0;
    else if (io_bus.bias_we) r_bias <= io_bus.bias_in;
  // stage 1: one extra bit of headroom so the bias add can never wrap
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sum <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= 1'b1;
      r_s1_sum <= {io_bus.in_sum[sum_w-1], io_bus.in_sum} + {r_bias[sum_w-1], r_bias};
    end else if (w_s1_adv) r_s1_valid <= 1'b0;
  // stage 2: result only changes when a real sample moves in, so it holds under stall
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_act <= '0;
      r_out_sat <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_act <= w_act;
        r_out_sat <= w_over;
      end
    end
  // clip-event counter sticks at full scale; clear wins over a coincident clipped handshake
  always_ff @(posedge clk)
    if (!rst_n || io_bus.sat_clr) r_sat_count <= '0;
    else if (r_out_valid && io_bus.out_ready && r_out_sat && r_sat_count != '1) r_sat_count <= r_sat_count + cnt_w'(1);
endmodule
